// File: rtl/shift4_reg.sv
// -----------------------------------------------------------------------------
// shift4_reg
//   Parallel-load, right-shifting register, `size` bits wide (default 4).
//   On each rising clk edge the register either loads a parallel word, shifts
//   right by one position, or holds. q always shows the register contents
//   directly; there is no combinational path from any input to q.
//
//   Ports
//     clk     in   1     rising-edge clock
//     areset  in   1     asynchronous active-high clear of the register
//     load    in   1     parallel load enable (wins over ena)
//     ena     in   1     shift-right enable
//     data    in   size  parallel load value, sampled only when load=1
//     q       out  size  register contents
//
//   Build option
//     SHIFT4_ROTATE_EN  when defined, an ena shift rotates right (q[0] wraps
//                       into the MSB) instead of zero-filling. Default build
//                       (undefined) is a logical shift right.
// -----------------------------------------------------------------------------
module shift4_reg #(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            areset,
  input  logic            load,
  input  logic            ena,
  input  logic [size-1:0] data,
  output logic [size-1:0] q
);

  logic [size-1:0] r_q;
  logic [size-1:0] w_q_next;

  // One-position right move. The LSB is either discarded (zero fill) or
  // wrapped into the MSB, depending on the build.
  function automatic logic [size-1:0] shift_right(input logic [size-1:0] v);
`ifdef SHIFT4_ROTATE_EN
    return {v[0], v[size-1:1]};
`else
    return {1'b0, v[size-1:1]};
`endif
  endfunction

  // Next-state select: load > ena > hold. data is only consulted on the
  // load branch, so an undriven bus never reaches the register otherwise.
  always_comb begin
    w_q_next = r_q;
    if (load) begin
      w_q_next = data;
    end else if (ena) begin
      w_q_next = shift_right(r_q);
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign q = r_q;

endmodule

// File: tb/tb_shift4_reg.sv
// -----------------------------------------------------------------------------
// tb_shift4_reg
//   Directed-vector bench for shift4_reg (size = 4). Inputs are changed 1 ns
//   after a rising edge and q is sampled 1 ns after the next rising edge, so
//   each step() covers exactly one register update. Expected values are
//   hand-computed constants. Build with +define+SHIFT4_ROTATE_EN to exercise
//   the rotate variant instead of the zero-fill shift sequences.
// -----------------------------------------------------------------------------
module tb_shift4_reg;

  logic       clk = 1'b0;
  logic       areset;
  logic       load;
  logic       ena;
  logic [3:0] data;
  logic [3:0] q;

  int n_tests = 0;
  int n_fail  = 0;

  shift4_reg #(.size(4)) dut (
    .clk    (clk),
    .areset (areset),
    .load   (load),
    .ena    (ena),
    .data   (data),
    .q      (q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: q=%b expected %b", tag, got, exp);
    end
  endtask

  // Apply one set of controls, let one rising edge pass, sample 1 ns later.
  task automatic step(input logic l, input logic e, input logic [3:0] d);
    load = l;
    ena  = e;
    data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    areset = 1'b1;
    load   = 1'b0;
    ena    = 1'b0;
    data   = 4'b0000;
    @(posedge clk);
    #1;
    chk("reset_state", q, 4'b0000);

    // Reset overrides a pending load across an edge.
    step(1'b1, 1'b0, 4'b1111);
    chk("reset_over_load", q, 4'b0000);
    areset = 1'b0;

    // Load, then hold with an unrelated / unknown data bus.
    step(1'b1, 1'b0, 4'b1111);
    chk("load_1111", q, 4'b1111);
    step(1'b0, 1'b0, 4'b0000);
    chk("hold_data_ignored", q, 4'b1111);
    step(1'b0, 1'b0, 4'bxxxx);
    chk("hold_data_x", q, 4'b1111);

`ifndef SHIFT4_ROTATE_EN
    // Zero-fill shift from all ones, then hold.
    step(1'b0, 1'b1, 4'b1010);
    chk("shift1", q, 4'b0111);
    step(1'b0, 1'b1, 4'b1010);
    chk("shift2", q, 4'b0011);
    step(1'b0, 1'b0, 4'b1010);
    chk("hold_after_shift_a", q, 4'b0011);
    step(1'b0, 1'b0, 4'b1010);
    chk("hold_after_shift_b", q, 4'b0011);

    // Drain 1011 to zero, and zero stays zero.
    step(1'b1, 1'b0, 4'b1011);
    chk("load_1011", q, 4'b1011);
    step(1'b0, 1'b1, 4'b1111);
    chk("drain1", q, 4'b0101);
    step(1'b0, 1'b1, 4'b1111);
    chk("drain2", q, 4'b0010);
    step(1'b0, 1'b1, 4'b1111);
    chk("drain3", q, 4'b0001);
    step(1'b0, 1'b1, 4'b1111);
    chk("drain4", q, 4'b0000);
    step(1'b0, 1'b1, 4'b1111);
    chk("drain_zero_stays", q, 4'b0000);
`else
    // Rotate: 0001 walks round and returns after four edges.
    step(1'b1, 1'b0, 4'b0001);
    chk("rot_load_0001", q, 4'b0001);
    step(1'b0, 1'b1, 4'b0110);
    chk("rot1", q, 4'b1000);
    step(1'b0, 1'b1, 4'b0110);
    chk("rot2", q, 4'b0100);
    step(1'b0, 1'b1, 4'b0110);
    chk("rot3", q, 4'b0010);
    step(1'b0, 1'b1, 4'b0110);
    chk("rot4", q, 4'b0001);
    step(1'b0, 1'b0, 4'b0110);
    chk("rot_hold", q, 4'b0001);
    step(1'b1, 1'b0, 4'b1011);
    chk("rot_load_1011", q, 4'b1011);
    step(1'b0, 1'b1, 4'b0000);
    chk("rot_1011_a", q, 4'b1101);
    step(1'b0, 1'b1, 4'b0000);
    chk("rot_1011_b", q, 4'b1110);
`endif

    // Load beats shift when both are high.
    step(1'b1, 1'b0, 4'b0011);
    chk("load_0011", q, 4'b0011);
    step(1'b1, 1'b1, 4'b1000);
    chk("priority_load", q, 4'b1000);

    // Asynchronous reset raised between edges clears q before the next edge.
    step(1'b1, 1'b0, 4'b0011);
    chk("preload_0011", q, 4'b0011);
    load = 1'b0;
    ena  = 1'b0;
    #3;
    areset = 1'b1;
    #1;
    chk("async_clear", q, 4'b0000);
    step(1'b1, 1'b1, 4'b1111);
    chk("reset_held_edge1", q, 4'b0000);
    step(1'b0, 1'b1, 4'b1111);
    chk("reset_held_edge2", q, 4'b0000);
    areset = 1'b0;
    step(1'b0, 1'b0, 4'b1111);
    chk("release_hold", q, 4'b0000);
    step(1'b1, 1'b0, 4'b0101);
    chk("load_after_reset", q, 4'b0101);

    // Reset in the middle of a shift sequence discards state.
    step(1'b0, 1'b1, 4'b0000);
`ifndef SHIFT4_ROTATE_EN
    chk("midshift", q, 4'b0010);
`else
    chk("midshift", q, 4'b1010);
`endif
    #3;
    areset = 1'b1;
    #1;
    chk("midshift_clear", q, 4'b0000);
    @(posedge clk);
    #1;
    areset = 1'b0;
    step(1'b0, 1'b0, 4'b1111);
    chk("midshift_no_resume", q, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
